// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - req/ack data-memory bus between the MEM-stage controller and memory
//
// Purpose: bundles the multi-cycle memory bus so the controller and the memory
// model connect through a single port.
// Signals:
//   bus_req   master->slave  request held high until the access ends
//   bus_we    master->slave  1 = write, 0 = read
//   bus_addr  master->slave  access address (ADDR_W)
//   bus_wdata master->slave  write data (DATA_W)
//   bus_ack   slave->master  single-cycle completion strobe
//   bus_rdata slave->master  read data, valid with bus_ack (DATA_W)
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store controller driving a req/ack memory bus
//
// Purpose: turns EX/MEM load/store requests into one bus transaction each,
// stalls the pipeline while the bus is busy, returns load data to MEM/WB and
// aborts with a one-cycle fault pulse when the bus never acknowledges.
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   mem_rd_en     EX/MEM holds a load
//   mem_wr_en     EX/MEM holds a store
//   mem_addr      access address
//   mem_wdata     store data
//   flush         flush_ex_mem from the hazard unit
//   pipe_hold     stall_ex_mem from the hazard unit
//   mem_stall     stall request to the hazard unit (combinational)
//   mem_rdata     registered load result
//   mem_fault     one-cycle pulse on bus timeout
//   bus           memory bus, master side
module mem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_rd_en,
  input  logic                 mem_wr_en,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_wdata,
  input  logic                 flush,
  input  logic                 pipe_hold,
  output logic                 mem_stall,
  output logic [DATA_W-1:0]    mem_rdata,
  output logic                 mem_fault,
  mem_access_ctrl_if.master    bus
);

  localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, SQUASH, DONE} state_t;

  state_t     state;
  logic [9:0] cnt;
  logic       timeout_hit;

  // The cycle that would make the count reach TIMEOUT is the last one allowed.
  assign timeout_hit = (cnt + 10'd1) == TIMEOUT_CNT;

  // pipe_hold is deliberately absent here so no loop forms through the hazard unit.
  always_comb begin
    mem_stall = 1'b0;
    case (state)
      IDLE:        mem_stall = (mem_rd_en | mem_wr_en) & ~flush;
      REQ, SQUASH: mem_stall = 1'b1;
      DONE:        mem_stall = 1'b0;
      default:     mem_stall = 1'b0;
    endcase
    if (rst) mem_stall = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 10'd0;
      mem_rdata     <= '0;
      mem_fault     <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
    end else begin
      mem_fault <= 1'b0;
      case (state)
        IDLE: begin
          if ((mem_rd_en | mem_wr_en) & ~flush) begin
            bus.bus_addr  <= mem_addr;
            bus.bus_wdata <= mem_wdata;
            bus.bus_we    <= mem_wr_en;
            bus.bus_req   <= 1'b1;
            cnt           <= 10'd0;
            state         <= REQ;
          end
        end
        REQ: begin
          cnt <= cnt + 10'd1;
          // ack beats both timeout and flush; timeout beats flush so the
          // request is never left dangling past the limit.
          if (bus.bus_ack) begin
            if (!bus.bus_we) mem_rdata <= bus.bus_rdata;
            bus.bus_req <= 1'b0;
            state       <= DONE;
          end else if (timeout_hit) begin
            bus.bus_req <= 1'b0;
            mem_fault   <= 1'b1;
            state       <= DONE;
          end else if (flush) begin
            state <= SQUASH;
          end
        end
        SQUASH: begin
          // The bus cannot retract the request, so wait it out; the count
          // keeps running from REQ so the overall limit still holds.
          cnt <= cnt + 10'd1;
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            state       <= IDLE;
          end else if (timeout_hit) begin
            bus.bus_req <= 1'b0;
            mem_fault   <= 1'b1;
            state       <= IDLE;
          end
        end
        DONE: begin
          // Leaving only via IDLE keeps the held instruction from re-issuing.
          if (!pipe_hold) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl with a transaction-level model
module tb_mem_access_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0, wr_en = 1'b0, flush = 1'b0, pipe_hold = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic        mem_stall, mem_fault;
  logic [31:0] mem_rdata;
  logic [31:0] exp_rdata = '0;
  int          checks = 0;
  int          failures = 0;

  mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_rd_en (rd_en),
    .mem_wr_en (wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .flush     (flush),
    .pipe_hold (pipe_hold),
    .mem_stall (mem_stall),
    .mem_rdata (mem_rdata),
    .mem_fault (mem_fault),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access seen from the pipeline. k = ack cycle (beyond T means never),
  // c = flush cycle (0 = in IDLE, negative = none), h = DONE hold cycles.
  task automatic access(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdat, input int k, input int c, input int h);
    int   e;
    logic sq, flt, wr, live;
    wr  = ~rd;
    e   = (k < T) ? k : T;
    sq  = (c >= 1) && (c < e);
    flt = (k > T);

    step();
    rd_en = rd; wr_en = wr; mem_addr = addr; mem_wdata = wdata;
    flush = (c == 0); bus.bus_ack = 1'b0; pipe_hold = 1'b0;
    #1;
    chk("stall_c0", mem_stall, (c == 0) ? 32'd0 : 32'd1);
    if (c == 0) begin
      step();
      rd_en = 1'b0; wr_en = 1'b0; flush = 1'b0;
      #1;
      chk("noreq_after_idle_flush", bus.bus_req, 0);
      chk("stall_after_idle_flush", mem_stall, 0);
      return;
    end

    for (int t = 1; t <= e; t++) begin
      step();
      live = !(c >= 1 && t > c);
      rd_en = rd & live; wr_en = wr & live;
      flush = (t == c);
      bus.bus_ack = (t == k);
      bus.bus_rdata = (t == k) ? rdat : $urandom;
      #1;
      chk("req_busy", bus.bus_req, 1);
      chk("we_busy", bus.bus_we, wr);
      chk("addr_busy", bus.bus_addr, addr);
      chk("wdata_busy", bus.bus_wdata, wdata);
      chk("stall_busy", mem_stall, 1);
      chk("fault_busy", mem_fault, 0);
    end
    if (rd && !flt && !sq) exp_rdata = rdat;

    step();
    bus.bus_ack = 1'b0; flush = 1'b0;
    rd_en = sq ? 1'b0 : rd; wr_en = sq ? 1'b0 : wr;
    pipe_hold = !sq && (h > 0);
    #1;
    chk("req_end", bus.bus_req, 0);
    chk("stall_end", mem_stall, 0);
    chk("fault_end", mem_fault, flt);
    chk("rdata_end", mem_rdata, exp_rdata);

    if (!sq) begin
      for (int j = 1; j <= h; j++) begin
        step();
        pipe_hold = (j < h);
        bus.bus_ack = 1'($urandom_range(0, 1));
        bus.bus_rdata = $urandom;
        #1;
        chk("req_hold", bus.bus_req, 0);
        chk("stall_hold", mem_stall, 0);
        chk("fault_hold", mem_fault, 0);
        chk("rdata_hold", mem_rdata, exp_rdata);
      end
    end

    step();
    rd_en = 1'b0; wr_en = 1'b0; pipe_hold = 1'b0; bus.bus_ack = 1'b0;
    #1;
    chk("req_gap", bus.bus_req, 0);
    chk("stall_gap", mem_stall, 0);
    chk("fault_gap", mem_fault, 0);
  endtask

  initial begin
    bus.bus_ack = 1'b0;
    bus.bus_rdata = '0;

    // reset state, with a request present to show the stall is masked
    rd_en = 1'b1;
    #1;
    chk("rst_stall", mem_stall, 0);
    chk("rst_req", bus.bus_req, 0);
    chk("rst_we", bus.bus_we, 0);
    chk("rst_addr", bus.bus_addr, 0);
    chk("rst_wdata", bus.bus_wdata, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_fault", mem_fault, 0);
    rd_en = 1'b0;
    step();
    step();
    rst = 1'b0;

    // directed scenarios
    access(1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 3, -1, 0);   // load, ack at 3
    access(1'b0, 32'h200, 32'h12345678, 32'hAAAA5555, 1, -1, 0); // store, ack at 1
    access(1'b1, 32'h300, 32'h0, 32'h11111111, 2, 0, 0);    // flush in IDLE
    access(1'b1, 32'h304, 32'h0, 32'h22222222, 4, 2, 0);    // flush in REQ -> squash
    access(1'b1, 32'h308, 32'h0, 32'h33333333, 1000, -1, 0); // timeout
    access(1'b1, 32'h30C, 32'h0, 32'h44444444, 2, -1, 2);   // hold in DONE
    access(1'b1, 32'h310, 32'h0, 32'h55555555, 3, 3, 0);    // ack and flush together
    access(1'b0, 32'h314, 32'h9, 32'h0, 1000, 2, 0);        // timeout while squashed

    // async reset between edges in REQ
    step();
    rd_en = 1'b1; mem_addr = 32'h400; mem_wdata = 32'h0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", bus.bus_req, 0);
    chk("arst_stall", mem_stall, 0);
    rd_en = 1'b0;
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'hCAFEF00D;
    step();
    chk("arst_fault", mem_fault, 0);
    rst = 1'b0;
    exp_rdata = '0;
    step();
    #1;
    chk("post_rst_req", bus.bus_req, 0);
    chk("post_rst_we", bus.bus_we, 0);
    chk("post_rst_addr", bus.bus_addr, 0);
    chk("post_rst_rdata", mem_rdata, 0);
    chk("post_rst_fault", mem_fault, 0);
    chk("post_rst_stall", mem_stall, 0);
    bus.bus_ack = 1'b0;
    step();
    chk("late_ack_rdata", mem_rdata, 0);
    chk("late_ack_req", bus.bus_req, 0);

    // randomized accesses against the model
    for (int n = 0; n < 40; n++) begin
      logic rd;
      int   k, c, h;
      rd = 1'($urandom_range(0, 1));
      k  = $urandom_range(1, T + 2);
      c  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, T + 1) : -1;
      h  = $urandom_range(0, 2);
      access(rd, $urandom, $urandom, $urandom, k, c, h);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage data-memory access controller. Turns load/store requests from the EX/MEM buffer into a req/ack transaction on a multi-cycle memory bus.
- It is the source of the hazard unit's `mem_stall` input. It consumes the hazard unit's `flush_ex_mem` and `stall_ex_mem` outputs.
- Load data goes to the MEM/WB buffer.
- A bus timeout raises a one-cycle fault pulse.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum cycles in REQ without `bus_ack` before abort; legal range 1..1023; counter is 10 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_rd_en  in  1  EX/MEM instruction is a load.
- mem_wr_en  in  1  EX/MEM instruction is a store; rd_en and wr_en are never both 1.
- mem_addr  in  ADDR_W  access address.
- mem_wdata  in  DATA_W  store data.
- flush  in  1  `flush_ex_mem` from the hazard unit.
- pipe_hold  in  1  `stall_ex_mem` from the hazard unit.
- mem_stall  out  1  to the hazard unit; combinational.
- mem_rdata  out  DATA_W  registered load result to MEM/WB.
- mem_fault  out  1  one-cycle pulse on timeout.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_ack  in  1  single-cycle completion strobe.
- bus_rdata  in  DATA_W  read data, valid with `bus_ack`.

Behaviour:
- Reset:
  - State = IDLE; timeout counter = 0.
  - mem_rdata, bus_req, bus_we, bus_addr, bus_wdata and mem_fault are all 0.
  - mem_stall is forced 0 while rst = 1.
  - Reset mid-transaction drops bus_req immediately. The access is abandoned, with no fault pulse.
- States: IDLE, REQ, SQUASH, DONE. State and bus outputs are registered.
- mem_stall:
  - In IDLE: mem_stall = (mem_rd_en | mem_wr_en) & ~flush.
  - In REQ and SQUASH: mem_stall = 1.
  - In DONE: mem_stall = 0.
  - mem_stall never depends combinationally on pipe_hold, so there is no loop through the hazard unit.
- IDLE:
  - If (rd_en | wr_en) & ~flush: latch addr, wdata and we=wr_en into the bus registers; set bus_req = 1; clear the counter; go to REQ.
  - If flush is set, no access starts.
- REQ:
  - bus_req, bus_we, bus_addr and bus_wdata are held stable; the counter increments each cycle.
  - On bus_ack: if the access is a read, capture bus_rdata into mem_rdata. Then deassert bus_req next cycle and go to DONE.
  - If flush = 1 with no ack this cycle: go to SQUASH. The bus transaction cannot be retracted.
  - If ack and flush arrive in the same cycle: ack wins; the access completes normally and goes to DONE.
  - Timeout: if the counter reaches TIMEOUT with no ack, deassert bus_req, pulse mem_fault for 1 cycle, leave mem_rdata unchanged, and go to DONE.
- SQUASH:
  - Keep bus_req asserted until bus_ack, then go to IDLE. There is no DONE cycle, and mem_rdata is not updated (a squashed write still commits on the bus).
  - The timeout applies here too: go to IDLE with a mem_fault pulse.
- DONE:
  - mem_stall = 0, so the pipeline advances.
  - If pipe_hold = 1, stay in DONE holding mem_rdata. The same EX/MEM instruction must not be re-issued.
  - Otherwise go to IDLE.
  - While in DONE, a new rd_en/wr_en is ignored until IDLE is reached.
- Latency:
  - Request seen in IDLE at cycle 0; bus_req is high from cycle 1.
  - With ack at cycle k, mem_rdata is valid and mem_stall low at cycle k+1.
  - The minimum stall is 2 cycles (ack at cycle 1).
- bus_ack is ignored in IDLE and DONE.
- Back-to-back accesses: bus_req drops for at least 1 cycle (DONE) between transactions.

Test Plan:
1. Load with 3-cycle bus latency: rd_en=1, addr=0x100; ack at cycle 3 with rdata=0xDEADBEEF -> mem_stall high cycles 0–3, low at 4; mem_rdata=0xDEADBEEF at 4; bus_we=0.
2. Store: wr_en=1, addr=0x200, wdata=0x12345678; ack at cycle 1 -> bus_we=1 and bus_wdata=0x12345678 stable cycles 1–1; stall cycles 0–1; mem_rdata unchanged.
3. Flush in IDLE and in REQ:
   - rd_en=1 with flush=1 -> mem_stall=0, bus_req never rises.
   - Flush at cycle 2 of a read with ack at cycle 4 -> SQUASH; mem_stall high through cycle 4; IDLE at 5; mem_rdata keeps its old value.
4. Timeout with TIMEOUT=4 and no ack -> bus_req drops after 4 REQ cycles; mem_fault high exactly 1 cycle; then DONE with mem_stall=0.
5. pipe_hold in DONE: hold=1 for 2 cycles after completion -> stays in DONE; no second bus_req; mem_rdata stable; IDLE once hold=0.
6. Async reset asserted mid-REQ between clock edges -> bus_req=0 and mem_stall=0 immediately; IDLE and all outputs 0 after release; a late bus_ack is ignored.
